// File: rtl/gpu_scheduler.sv
// gpu_scheduler: frame sequencer and round-robin op arbiter for the gpu engine.
// Issues a clear op per frame, then clipped requester ops until all report last.
module gpu_scheduler #(
    parameter int   HOR_ACTIVE_PIXELS = 1920,
    parameter int   VER_ACTIVE_PIXELS = 1080,
    parameter int   NUM_REQ           = 4,
    parameter logic CLEAR_COLOR       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  frame_start,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*60-1:0] req_op,
    input  logic [NUM_REQ-1:0]    req_last,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic [59:0]           gpu_op,
    output logic                  gpu_op_valid,
    input  logic                  gpu_op_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_overrun
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [11:0] HOR = 12'(HOR_ACTIVE_PIXELS);
    localparam logic [11:0] VER = 12'(VER_ACTIVE_PIXELS);
    localparam logic [59:0] CLEAR_OP = {22'd0, HOR[10:0], VER[10:0], CLEAR_COLOR, 15'd0};

    typedef enum logic [1:0] {IDLE, WAIT, ARB, DONE} state_t;

    state_t             state, state_d;
    logic [IW-1:0]      rr_ptr, rr_ptr_d, src, src_d;
    logic               src_clr, src_clr_d, last_q, last_d;
    logic [NUM_REQ-1:0] done_mask, done_mask_d, req_ack_d;
    logic [59:0]        gpu_op_d;
    logic               gpu_op_valid_d, busy_d, frame_done_d, frame_overrun_d;

    logic [NUM_REQ-1:0] elig;
    logic               found, sel_last, drop, all_done;
    logic [IW-1:0]      gnt, cand;
    logic [59:0]        sel_op, clip_op;
    logic [11:0]        x, y, w, h, rem_w, rem_h;

    // An ack still visible means that requester has not yet advanced its op.
    assign elig     = req_valid & ~done_mask & ~req_ack;
    assign all_done = &done_mask;

    always_comb begin
        found = 1'b0;
        gnt   = rr_ptr;
        cand  = rr_ptr;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && elig[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
    end

    assign sel_op   = req_op[int'(gnt)*60 +: 60];
    assign sel_last = req_last[gnt];
    assign x        = {1'b0, sel_op[59:49]};
    assign y        = {1'b0, sel_op[48:38]};
    assign w        = {1'b0, sel_op[37:27]};
    assign h        = {1'b0, sel_op[26:16]};
    assign rem_w    = HOR - x;
    assign rem_h    = VER - y;
    assign drop     = (x >= HOR) || (y >= VER) || (w == 12'd0) || (h == 12'd0);
    assign clip_op  = {sel_op[59:38],
                       (w > rem_w) ? rem_w[10:0] : w[10:0],
                       (h > rem_h) ? rem_h[10:0] : h[10:0],
                       sel_op[15:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= IW'(NUM_REQ - 1);
            src           <= '0;
            src_clr       <= 1'b0;
            last_q        <= 1'b0;
            done_mask     <= '0;
            req_ack       <= '0;
            gpu_op        <= '0;
            gpu_op_valid  <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            frame_overrun <= 1'b0;
        end else if (ce) begin
            state         <= state_d;
            rr_ptr        <= rr_ptr_d;
            src           <= src_d;
            src_clr       <= src_clr_d;
            last_q        <= last_d;
            done_mask     <= done_mask_d;
            req_ack       <= req_ack_d;
            gpu_op        <= gpu_op_d;
            gpu_op_valid  <= gpu_op_valid_d;
            busy          <= busy_d;
            frame_done    <= frame_done_d;
            frame_overrun <= frame_overrun_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (frame_start) state_d = WAIT;
            WAIT: if (gpu_op_ready) state_d = ARB;
            ARB: begin
                if (all_done) state_d = DONE;
                else if (found && !drop) state_d = WAIT;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d        = rr_ptr;
        src_d           = src;
        src_clr_d       = src_clr;
        last_d          = last_q;
        done_mask_d     = done_mask;
        gpu_op_d        = gpu_op;
        busy_d          = busy;
        req_ack_d       = '0;
        gpu_op_valid_d  = 1'b0;
        frame_done_d    = 1'b0;
        frame_overrun_d = frame_start && (state != IDLE);
        unique case (state)
            IDLE: begin
                if (frame_start) begin
                    gpu_op_d       = CLEAR_OP;
                    src_clr_d      = 1'b1;
                    last_d         = 1'b0;
                    done_mask_d    = '0;
                    busy_d         = 1'b1;
                    gpu_op_valid_d = 1'b1;
                end
            end
            WAIT: begin
                if (gpu_op_ready && !src_clr) begin
                    req_ack_d[src] = 1'b1;
                    if (last_q) done_mask_d[src] = 1'b1;
                end
            end
            ARB: begin
                if (!all_done && found) begin
                    rr_ptr_d = gnt;
                    if (drop) begin
                        req_ack_d[gnt] = 1'b1;
                        if (sel_last) done_mask_d[gnt] = 1'b1;
                    end else begin
                        gpu_op_d       = clip_op;
                        last_d         = sel_last;
                        src_d          = gnt;
                        src_clr_d      = 1'b0;
                        gpu_op_valid_d = 1'b1;
                    end
                end
            end
            DONE: begin
                frame_done_d = 1'b1;
                busy_d       = 1'b0;
            end
            default: ;
        endcase
    end
endmodule
